// File: rtl/mem_bus_arbiter_pkg.sv
// Shared memory-request types for the bus arbiter and the mem stage.
package mem_bus_arbiter_pkg;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  typedef struct packed {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } memreq_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module mem_bus_arbiter_rr_pick #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [1:0]         i_ptr,
  output logic               o_any,
  output logic [1:0]         o_idx
);

  logic [1:0] w_j;

  // Scan from the farthest offset down so the nearest candidate is written last.
  always_comb begin
    o_any = 1'b0;
    o_idx = 2'd0;
    w_j   = 2'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_j = 2'((int'(i_ptr) + k) % NUM_REQ);
      if (i_req[w_j]) begin
        o_any = 1'b1;
        o_idx = w_j;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one pulse-protocol memory bus among NUM_REQ requesters,
// with one pending slot per requester and a single outstanding downstream transaction.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_REQ-1:0]    s_request_enable,
  input  logic [NUM_REQ-1:0]    s_mode,
  input  logic [32*NUM_REQ-1:0] s_addr,
  input  logic [32*NUM_REQ-1:0] s_wdata,
  input  logic [4*NUM_REQ-1:0]  s_wstrb,
  output logic [NUM_REQ-1:0]    s_response_enable,
  output logic [31:0]           s_data,
  output logic                  m_request_enable,
  output logic                  m_mode,
  output logic [31:0]           m_addr,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_wstrb,
  input  logic                  m_response_enable,
  input  logic [31:0]           m_data,
  output logic [1:0]            grant_id,
  output logic                  busy,
  output logic                  proto_err
);

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  arb_state_t         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_slot_vld;
  memreq_t            r_slot [NUM_REQ];
  logic [1:0]         r_ptr;

  memreq_t            w_live [NUM_REQ];
  memreq_t            w_win_req;
  logic [NUM_REQ-1:0] w_cand, w_cap, w_drop, w_clr;
  logic               w_any, w_issue, w_done;
  logic [1:0]         w_win;

  // Live pulses bypass the slots so an idle arbiter issues on the very next cycle.
  assign w_cand = r_slot_vld | s_request_enable;

  mem_bus_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req (w_cand),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_idx (w_win)
  );

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= ARB_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ARB_IDLE: if (w_any) begin
        w_issue     = 1'b1;
        w_state_nxt = ARB_WAIT;
      end
      ARB_WAIT: if (m_response_enable) begin
        w_done      = 1'b1;
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // A pulse is illegal if its slot is full or its owner is still waiting on the bus.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_live[i].mode  = s_mode[i];
      w_live[i].addr  = s_addr[32*i +: 32];
      w_live[i].wdata = s_wdata[32*i +: 32];
      w_live[i].wstrb = s_wstrb[4*i +: 4];
      w_drop[i] = s_request_enable[i] &&
                  (r_slot_vld[i] || (r_state == ARB_WAIT && grant_id == 2'(i)));
      w_cap[i]  = s_request_enable[i] && !w_drop[i] && !(w_issue && w_win == 2'(i));
    end
    w_win_req = r_slot_vld[w_win] ? r_slot[w_win] : w_live[w_win];
    w_clr     = w_issue ? (ONE << w_win) : '0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_cap[i]) r_slot[i] <= w_live[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_slot_vld        <= '0;
      r_ptr             <= 2'd0;
      s_response_enable <= '0;
      s_data            <= '0;
      m_request_enable  <= 1'b0;
      m_mode            <= 1'b0;
      m_addr            <= '0;
      m_wdata           <= '0;
      m_wstrb           <= '0;
      grant_id          <= 2'd0;
      busy              <= 1'b0;
      proto_err         <= 1'b0;
    end else begin
      r_slot_vld        <= (r_slot_vld | w_cap) & ~w_clr;
      m_request_enable  <= w_issue;
      s_response_enable <= '0;
      if (|w_drop) proto_err <= 1'b1;
      if (w_issue) begin
        m_mode   <= w_win_req.mode;
        m_addr   <= w_win_req.addr;
        m_wdata  <= w_win_req.wdata;
        m_wstrb  <= w_win_req.wstrb;
        grant_id <= w_win;
        busy     <= 1'b1;
        r_ptr    <= (w_win == 2'(NUM_REQ - 1)) ? 2'd0 : w_win + 2'd1;
      end
      if (w_done) begin
        s_response_enable <= ONE << grant_id;
        s_data            <= m_data;
        busy              <= 1'b0;
      end
    end
  end

endmodule
